spinner_emu: RTL and testbench

SPINNER_EMU -- requirements
Module: spinner_emu

---
 rtl/spinner_pkg.sv | 38 +++
 rtl/spinner_channel.sv | 103 ++++++++++
 rtl/spinner_emu.sv | 74 +++++++
 tb/tb_spinner_emu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types and defaults for the spinner/paddle emulator: quadrature
// direction, Gray-code sequencing and the timing defaults for a 48 MHz clock.
package spinner_pkg;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  localparam int CHANNELS_DEF    = 2;
  localparam int POS_W_DEF       = 12;
  localparam int CE_DIV_DEF      = 8;
  localparam int STEP_DIV_DEF    = 1500;
  localparam int DPAD_PERIOD_DEF = 48000;
  localparam int DPAD_SLOW_DEF   = 4;
  localparam int DPAD_FAST_DEF   = 9;
  localparam int ABS_MAX_DEF     = 255;
  localparam int ABS_CENTER_DEF  = 128;

  // Positive walks 00->10->11->01->00, negative walks the same ring backwards.
  function automatic logic [1:0] gray_next(input logic [1:0] q, input dir_e dir);
    logic [1:0] n;
    if (dir == DIR_POS) begin
      case (q)
        2'b00:   n = 2'b10;
        2'b10:   n = 2'b11;
        2'b11:   n = 2'b01;
        default: n = 2'b00;
      endcase
    end else begin
      case (q)
        2'b00:   n = 2'b01;
        2'b01:   n = 2'b11;
        2'b11:   n = 2'b10;
        default: n = 2'b00;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/spinner_channel.sv
// One spinner channel: signed pending-step accumulator, D-pad repeat timer,
// quadrature phase state and saturating absolute position.
module spinner_channel import spinner_pkg::*; #(
  parameter int POS_W       = POS_W_DEF,
  parameter int DPAD_PERIOD = DPAD_PERIOD_DEF,
  parameter int DPAD_SLOW   = DPAD_SLOW_DEF,
  parameter int DPAD_FAST   = DPAD_FAST_DEF,
  parameter int ABS_MAX     = ABS_MAX_DEF,
  parameter int ABS_CENTER  = ABS_CENTER_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       step_tick,
  input  logic       delta_strobe,
  input  logic [8:0] delta,
  input  logic       dpad_left,
  input  logic       dpad_right,
  input  logic       dpad_fast,
  input  logic       invert,
  output logic [1:0] quad,
  output logic [7:0] abs_pos,
  output logic       busy
);

  localparam int DCNT_W = $clog2(DPAD_PERIOD + 1);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] MAG_SLOW = POS_W'(DPAD_SLOW);
  localparam logic signed [POS_W-1:0] MAG_FAST = POS_W'(DPAD_FAST);

  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [1:0]              quad_q, quad_d;
  logic [7:0]              abs_q, abs_d;
  logic                    busy_q, busy_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;

  logic                    step;
  dir_e                    dir;
  logic signed [POS_W:0]   sum;
  logic signed [POS_W-1:0] sat_sum, pos_step, mag, dval;
  logic                    dload;

  always_comb begin
    step = step_tick && (pos_q != '0);
    dir  = (pos_q[POS_W-1] ^ invert) ? DIR_NEG : DIR_POS;

    quad_d = step ? gray_next(quad_q, dir) : quad_q;
    abs_d  = abs_q;
    if (step) begin
      if (dir == DIR_POS) abs_d = (abs_q == 8'(ABS_MAX)) ? abs_q : abs_q + 8'd1;
      else                abs_d = (abs_q == 8'd0)        ? abs_q : abs_q - 8'd1;
    end
    pos_step = pos_q[POS_W-1] ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

    // One extra bit makes overflow visible as a mismatch of the top two bits.
    sum = {pos_q[POS_W-1], pos_q} + {{(POS_W-8){delta[8]}}, delta};
    if (sum[POS_W] != sum[POS_W-1]) sat_sum = sum[POS_W] ? POS_MIN : POS_MAX;
    else                            sat_sum = sum[POS_W-1:0];

    dload  = 1'b0;
    dcnt_d = dcnt_q;
    if (!(dpad_left ^ dpad_right)) begin
      dcnt_d = '0;
    end else if (ce) begin
      if (dcnt_q == DCNT_W'(DPAD_PERIOD - 1)) begin
        dload  = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
    mag  = dpad_fast ? MAG_FAST : MAG_SLOW;
    dval = dpad_right ? mag : -mag;

    pos_d = pos_q;
    if (delta_strobe) pos_d = sat_sum;
    else if (dload)   pos_d = dval;
    else if (step)    pos_d = pos_step;
    busy_d = (pos_d != '0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pos_q  <= '0;
      quad_q <= 2'b00;
      abs_q  <= 8'(ABS_CENTER);
      busy_q <= 1'b0;
      dcnt_q <= '0;
    end else begin
      pos_q  <= pos_d;
      quad_q <= quad_d;
      abs_q  <= abs_d;
      busy_q <= busy_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign quad    = quad_q;
  assign abs_pos = abs_q;
  assign busy    = busy_q;

endmodule

// File: rtl/spinner_emu.sv
// Multi-channel spinner emulator: shared ce divider and step-rate counter
// feeding CHANNELS independent quadrature/paddle channels.
module spinner_emu import spinner_pkg::*; #(
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int CE_DIV      = CE_DIV_DEF,
  parameter int STEP_DIV    = STEP_DIV_DEF,
  parameter int DPAD_PERIOD = DPAD_PERIOD_DEF,
  parameter int DPAD_SLOW   = DPAD_SLOW_DEF,
  parameter int DPAD_FAST   = DPAD_FAST_DEF,
  parameter int ABS_MAX     = ABS_MAX_DEF,
  parameter int ABS_CENTER  = ABS_CENTER_DEF
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [CHANNELS-1:0]      delta_strobe,
  input  logic [CHANNELS-1:0][8:0] delta,
  input  logic [CHANNELS-1:0]      dpad_left,
  input  logic [CHANNELS-1:0]      dpad_right,
  input  logic [CHANNELS-1:0]      dpad_fast,
  input  logic [CHANNELS-1:0]      invert,
  output logic [CHANNELS-1:0][1:0] quad,
  output logic [CHANNELS-1:0][7:0] abs_pos,
  output logic [CHANNELS-1:0]      busy
);

  localparam int CE_W   = (CE_DIV > 1)   ? $clog2(CE_DIV)   : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CE_W-1:0]   ce_cnt_q, ce_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              ce, step_tick;

  always_comb begin
    ce        = (ce_cnt_q == CE_W'(CE_DIV - 1));
    ce_cnt_d  = ce ? '0 : ce_cnt_q + CE_W'(1);
    // Step opportunity lands on the ce whose step count is 0.
    step_tick = ce && (step_cnt_q == '0);
    step_cnt_d = step_cnt_q;
    if (ce) step_cnt_d = (step_cnt_q == STEP_W'(STEP_DIV - 1)) ? '0 : step_cnt_q + STEP_W'(1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt_q   <= '0;
      step_cnt_q <= '0;
    end else begin
      ce_cnt_q   <= ce_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    spinner_channel #(
      .POS_W(POS_W), .DPAD_PERIOD(DPAD_PERIOD), .DPAD_SLOW(DPAD_SLOW),
      .DPAD_FAST(DPAD_FAST), .ABS_MAX(ABS_MAX), .ABS_CENTER(ABS_CENTER)
    ) u_ch (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ce           (ce),
      .step_tick    (step_tick),
      .delta_strobe (delta_strobe[c]),
      .delta        (delta[c]),
      .dpad_left    (dpad_left[c]),
      .dpad_right   (dpad_right[c]),
      .dpad_fast    (dpad_fast[c]),
      .invert       (invert[c]),
      .quad         (quad[c]),
      .abs_pos      (abs_pos[c]),
      .busy         (busy[c])
    );
  end

endmodule

// File: tb/tb_spinner_emu.sv
// Bench for spinner_emu: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the spinner rules.
module tb_spinner_emu;
  localparam int CH = 2, CE_DIV = 4, STEP_DIV = 10, DPAD_PERIOD = 50;
  localparam int STEP_CYC = CE_DIV * STEP_DIV;
  localparam int PMAX = 2047, PMIN = -2048;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset_n;
  logic [CH-1:0]      delta_strobe, dpad_left, dpad_right, dpad_fast, invert;
  logic [CH-1:0][8:0] delta;
  logic [CH-1:0][1:0] quad;
  logic [CH-1:0][7:0] abs_pos;
  logic [CH-1:0]      busy;

  spinner_emu #(.CHANNELS(CH), .POS_W(12), .CE_DIV(CE_DIV), .STEP_DIV(STEP_DIV),
    .DPAD_PERIOD(DPAD_PERIOD), .DPAD_SLOW(4), .DPAD_FAST(9), .ABS_MAX(255),
    .ABS_CENTER(128)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .delta_strobe(delta_strobe), .delta(delta),
    .dpad_left(dpad_left), .dpad_right(dpad_right), .dpad_fast(dpad_fast),
    .invert(invert), .quad(quad), .abs_pos(abs_pos), .busy(busy));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position on the Gray ring as an index 0..3.
  int m_pos[CH], m_qi[CH], m_abs[CH], m_dcnt[CH];
  int m_cyc, m_ce;

  function automatic int qmap(input int qi);
    case (qi)
      0: return 0;       // 00
      1: return 2;       // 10
      2: return 3;       // 11
      default: return 1; // 01
    endcase
  endfunction

  function automatic bit pred_tick();
    return (m_cyc % CE_DIV == CE_DIV - 1) && (m_ce % STEP_DIV == 0);
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    bit ce, tk, dp, ld;
    int p, ns, s, mag;
    if (!reset_n) begin
      m_cyc = 0; m_ce = 0;
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = 0; m_qi[c] = 0; m_abs[c] = 128; m_dcnt[c] = 0;
      end
    end else begin
      ce = (m_cyc % CE_DIV == CE_DIV - 1);
      tk = ce && (m_ce % STEP_DIV == 0);
      for (int c = 0; c < CH; c++) begin
        p = m_pos[c]; ns = p; ld = 0;
        if (tk && p != 0) begin
          dp = (p > 0) ^ invert[c];
          m_qi[c] = (m_qi[c] + (dp ? 1 : 3)) % 4;
          m_abs[c] = dp ? ((m_abs[c] < 255) ? m_abs[c] + 1 : 255)
                        : ((m_abs[c] > 0) ? m_abs[c] - 1 : 0);
          ns = (p > 0) ? p - 1 : p + 1;
        end
        if (dpad_left[c] == dpad_right[c]) m_dcnt[c] = 0;
        else if (ce) begin
          m_dcnt[c]++;
          if (m_dcnt[c] == DPAD_PERIOD) begin ld = 1; m_dcnt[c] = 0; end
        end
        if (delta_strobe[c]) begin
          s = p + int'($signed(delta[c]));
          ns = (s > PMAX) ? PMAX : (s < PMIN) ? PMIN : s;
        end else if (ld) begin
          mag = dpad_fast[c] ? 9 : 4;
          ns = dpad_right[c] ? mag : -mag;
        end
        m_pos[c] = ns;
      end
      m_cyc++;
      if (ce) m_ce++;
    end
  end

  function automatic int pos0();
    return int'(dut.g_ch[0].u_ch.pos_q);
  endfunction

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("quad%0d", c), int'(quad[c]), qmap(m_qi[c]));
      chk($sformatf("abs%0d", c), int'(abs_pos[c]), m_abs[c]);
      chk($sformatf("busy%0d", c), int'(busy[c]), int'(m_pos[c] != 0));
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    check_all();
    delta_strobe = '0;
  endtask

  task automatic pulse(input int c, input int d);
    delta[c] = 9'(d);
    delta_strobe[c] = 1'b1;
    tick();
  endtask

  task automatic wait_quad(input int c, input int bound, output int q, output int cyc);
    logic [1:0] q0;
    q0 = quad[c]; cyc = 0;
    while (quad[c] == q0 && cyc < bound) begin tick(); cyc++; end
    if (cyc >= bound) chk("quad_timeout", cyc, -1);
    q = int'(quad[c]);
  endtask

  task automatic wait_idle(input int c, input int bound);
    int cyc = 0;
    while (busy[c] && cyc < bound) begin tick(); cyc++; end
    chk("idle_timeout", int'(busy[c]), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int q, cyc, n;
    int a_exp[3] = '{2, 3, 1};
    int c_exp[3] = '{1, 3, 2};
    logic [1:0] qprev;
    reset_n = 1'b0;
    delta_strobe = '0; delta = '0; dpad_left = '0; dpad_right = '0;
    dpad_fast = '0; invert = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    for (int c = 0; c < CH; c++) begin
      chk("rst_quad", int'(quad[c]), 0);
      chk("rst_abs", int'(abs_pos[c]), 128);
      chk("rst_busy", int'(busy[c]), 0);
    end
    reset_n = 1'b1;

    // +3 on channel 0: three positive Gray steps one step period apart
    pulse(0, 3);
    for (int k = 0; k < 3; k++) begin
      wait_quad(0, STEP_CYC + 5, q, cyc);
      chk("a_quad", q, a_exp[k]);
      if (k > 0) chk("a_gap", cyc, STEP_CYC);
    end
    chk("a_ch1_quad", int'(quad[1]), 0);
    wait_idle(0, STEP_CYC + 5);
    chk("a_abs", int'(abs_pos[0]), 131);

    // accumulator saturation at both rails
    repeat (9) pulse(0, 255);
    pulse(0, 100);
    chk("sat_hi", pos0(), 2047);
    repeat (17) pulse(0, -256);
    pulse(0, -1);
    chk("sat_lo", pos0(), -2048);
    do_reset();

    // D-pad left + fast: load -9, walk the ring backwards
    dpad_left[0] = 1'b1; dpad_fast[0] = 1'b1;
    cyc = 0;
    while (!busy[0] && cyc < DPAD_PERIOD * CE_DIV + 10) begin tick(); cyc++; end
    chk("dp_load", pos0(), -9);
    dpad_left[0] = 1'b0; dpad_fast[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_quad(0, STEP_CYC + 5, q, cyc);
      chk("dp_quad", q, c_exp[k]);
    end
    wait_idle(0, 10 * STEP_CYC);
    dpad_left[0] = 1'b1; dpad_right[0] = 1'b1;
    repeat (3 * DPAD_PERIOD * CE_DIV) tick();
    chk("dp_both", pos0(), 0);
    dpad_left[0] = 1'b0; dpad_right[0] = 1'b0;

    // invert on channel 1
    do_reset();
    invert[1] = 1'b1;
    pulse(1, 1);
    wait_quad(1, STEP_CYC + 5, q, cyc);
    chk("inv_quad", q, 1);
    wait_idle(1, STEP_CYC + 5);
    chk("inv_abs", int'(abs_pos[1]), 127);
    invert[1] = 1'b0;

    // abs_pos pinned at 255 while quad keeps stepping
    do_reset();
    pulse(0, 127);
    wait_idle(0, 130 * STEP_CYC);
    chk("abs_top", int'(abs_pos[0]), 255);
    pulse(0, 5);
    n = 0; qprev = quad[0];
    repeat (7 * STEP_CYC) begin
      tick();
      if (quad[0] != qprev) begin n++; qprev = quad[0]; end
    end
    chk("abs_steps", n, 5);
    chk("abs_hold", int'(abs_pos[0]), 255);

    // reset asserted in the cycle of a step tick
    do_reset();
    pulse(0, 3);
    chk("iso_quad1", int'(quad[1]), 0);
    chk("iso_abs1", int'(abs_pos[1]), 128);
    chk("iso_busy1", int'(busy[1]), 0);
    cyc = 0;
    while (!pred_tick() && cyc < STEP_CYC + 5) begin tick(); cyc++; end
    reset_n = 1'b0;
    #1;
    for (int c = 0; c < CH; c++) begin
      chk("mid_quad", int'(quad[c]), 0);
      chk("mid_abs", int'(abs_pos[c]), 128);
      chk("mid_busy", int'(busy[c]), 0);
    end
    tick();
    reset_n = 1'b1;

    // random traffic against the model
    repeat (4000) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom % 16 == 0) begin
          delta[c] = 9'($urandom);
          delta_strobe[c] = 1'b1;
        end
        if ($urandom % 300 == 0) dpad_left[c]  = ~dpad_left[c];
        if ($urandom % 300 == 0) dpad_right[c] = ~dpad_right[c];
        if ($urandom % 200 == 0) dpad_fast[c]  = ~dpad_fast[c];
        if ($urandom % 500 == 0) invert[c]     = ~invert[c];
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
